// File: rtl/joy_pkg.sv
// Shared constants and helpers for the joystick conditioner.
// Vectors are indexed [0:4] in the pin order {fire, left, right, down, up}.
package joy_pkg;

    localparam int JOY_FIRE  = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_RIGHT = 2;
    localparam int JOY_DOWN  = 3;
    localparam int JOY_UP    = 4;
    localparam int JOY_BITS  = 5;
    localparam int NUM_PORTS = 2;

    typedef logic [0:JOY_BITS-1] joy_vec_t;

    // Opposing directions pressed together cancel when blocking is enabled.
    function automatic logic [1:0] socd_pair(input logic a, input logic b, input logic en);
        logic both;
        both = en & a & b;
        return {a & ~both, b & ~both};
    endfunction

endpackage

// File: rtl/joystick_conditioner_if.sv
// Joystick pin/bus bundle between the Pmod pins, the mainboard and the conditioner.
interface joystick_conditioner_if;
    import joy_pkg::*;

    joy_vec_t   joy1_raw;
    joy_vec_t   joy2_raw;
    logic [1:2] autofire_en;
    logic       socd_block;
    joy_vec_t   joy1;
    joy_vec_t   joy2;
    logic       joy_change;

    modport master (
        output joy1_raw, joy2_raw, autofire_en, socd_block,
        input  joy1, joy2, joy_change
    );

    modport slave (
        input  joy1_raw, joy2_raw, autofire_en, socd_block,
        output joy1, joy2, joy_change
    );

endinterface

// File: rtl/joy_port.sv
// One joystick port: 2-FF sync + invert, per-bit tick debounce, autofire, SOCD.
// changed_o is a registered pulse aligned with the cycle the debounced state moved.
module joy_port
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 8,
    parameter int AUTOFIRE_TICKS = 64
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     tick_i,
    input  joy_vec_t raw_i,
    input  logic     af_en_i,
    input  logic     socd_i,
    output joy_vec_t joy_o,
    output logic     changed_o
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int AW = $clog2(AUTOFIRE_TICKS + 1);

    joy_vec_t sync1_q, sync2_q, s;
    joy_vec_t d_q, d_d;
    joy_vec_t joy_q, joy_d;
    logic [JOY_BITS-1:0][CW-1:0] c_q, c_d;
    logic [AW-1:0] a_q, a_d;
    logic p_q, p_d;
    logic chg_q, chg_d;
    logic af_run;

    assign s = ~sync2_q;

    always_comb begin
        d_d = d_q;
        c_d = c_q;
        if (tick_i) begin
            for (int i = 0; i < JOY_BITS; i++) begin
                if (s[i] == d_q[i]) begin
                    c_d[i] = '0;
                end else if (c_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                    d_d[i] = s[i];
                    c_d[i] = '0;
                end else begin
                    c_d[i] = c_q[i] + 1'b1;
                end
            end
        end
    end

    // Using d_d lets a release accepted on a wrap tick win over the toggle.
    assign af_run = af_en_i & d_q[JOY_FIRE] & d_d[JOY_FIRE];

    always_comb begin
        a_d = a_q;
        p_d = p_q;
        if (!af_run) begin
            a_d = '0;
            p_d = 1'b1;
        end else if (tick_i) begin
            if (a_q == AW'(AUTOFIRE_TICKS - 1)) begin
                a_d = '0;
                p_d = ~p_q;
            end else begin
                a_d = a_q + 1'b1;
            end
        end
    end

    always_comb begin
        joy_d = d_q;
        joy_d[JOY_FIRE] = d_q[JOY_FIRE] & (af_en_i ? p_q : 1'b1);
        {joy_d[JOY_LEFT], joy_d[JOY_RIGHT]} = socd_pair(d_q[JOY_LEFT], d_q[JOY_RIGHT], socd_i);
        {joy_d[JOY_DOWN], joy_d[JOY_UP]}    = socd_pair(d_q[JOY_DOWN], d_q[JOY_UP], socd_i);
        chg_d = (d_d != d_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            d_q     <= '0;
            c_q     <= '0;
            a_q     <= '0;
            p_q     <= 1'b1;
            joy_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            d_q     <= d_d;
            c_q     <= c_d;
            a_q     <= a_d;
            p_q     <= p_d;
            joy_q   <= joy_d;
            chg_q   <= chg_d;
        end
    end

    assign joy_o     = joy_q;
    assign changed_o = chg_q;

endmodule

// File: rtl/joystick_conditioner.sv
// Top: sample-tick prescaler shared by both joystick ports, plus the change strobe.
// joy_change rises in the same cycle the conditioned vectors take a new debounced level.
module joystick_conditioner
    import joy_pkg::*;
#(
    parameter int TICK_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int AUTOFIRE_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    joystick_conditioner_if.slave  bus
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          joy_change_q;
    joy_vec_t      raw [NUM_PORTS];
    joy_vec_t      joy [NUM_PORTS];
    logic [NUM_PORTS-1:0] chg;

    assign tick  = (cnt_q == TW'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            joy_change_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            joy_change_q <= |chg;
        end
    end

    assign raw[0] = bus.joy1_raw;
    assign raw[1] = bus.joy2_raw;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        joy_port #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .AUTOFIRE_TICKS(AUTOFIRE_TICKS)
        ) u_port (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick_i    (tick),
            .raw_i     (raw[g]),
            .af_en_i   (bus.autofire_en[g+1]),
            .socd_i    (bus.socd_block),
            .joy_o     (joy[g]),
            .changed_o (chg[g])
        );
    end

    assign bus.joy1       = joy[0];
    assign bus.joy2       = joy[1];
    assign bus.joy_change = joy_change_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3, AUTOFIRE_TICKS=2.
// Inputs change on a negedge right after a tick edge, so a clean press lands 13 cycles later.
module tb_joystick_conditioner;
    import joy_pkg::*;

    localparam int TICK_DIV = 4;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    int   pulses = 0;
    logic chg_prev = 1'b0;
    logic long_pulse = 1'b0;

    joystick_conditioner_if bus ();

    joystick_conditioner #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(3), .AUTOFIRE_TICKS(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; a tick edge occurred at posedge k when k%4==0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        chg_prev <= bus.joy_change;
        if (bus.joy_change && !chg_prev) pulses <= pulses + 1;
        if (bus.joy_change && chg_prev)  long_pulse <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        while (cyc % TICK_DIV != 0) @(negedge clk);
    endtask

    task automatic wait_joy(input int port, input joy_vec_t exp, input int budget, output int n);
        joy_vec_t cur;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            cur = (port == 0) ? bus.joy1 : bus.joy2;
        end while (cur !== exp && n < budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, p0, hi;
        logic [23:0] got;
        logic seen;

        clk = 1'b0;
        reset_n = 1'b1;
        bus.joy1_raw    = 5'b00000;
        bus.joy2_raw    = 5'b11111;
        bus.autofire_en = 2'b00;
        bus.socd_block  = 1'b0;
        #2 reset_n = 1'b0;
        step(3);
        chk("rst_out", {bus.joy1, bus.joy2, bus.joy_change}, 0);

        // All port-1 pins pressed during reset.
        p0 = pulses;
        reset_n = 1'b1;
        wait_joy(0, 5'b11111, 20, n);
        chk("rst_lat", n, 13);
        chk("rst_chg", bus.joy_change, 1);
        step(3);
        chk("rst_pulse", pulses - p0, 1);
        chk("rst_joy2", bus.joy2, 5'b00000);

        align();
        bus.joy1_raw = 5'b11111;
        wait_joy(0, 5'b00000, 20, n);
        chk("rel_lat", n, 13);

        // Up bounces low for two ticks only.
        align();
        p0 = pulses;
        bus.joy1_raw = 5'b11110;
        step(8);
        bus.joy1_raw = 5'b11111;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            seen |= bus.joy1[JOY_UP];
        end
        chk("glitch_up", seen, 0);
        chk("glitch_chg", pulses - p0, 0);

        align();
        bus.joy1_raw = 5'b11110;
        wait_joy(0, 5'b00001, 20, n);
        chk("up_lat", n, 13);
        chk("up_chg", bus.joy_change, 1);

        // Autofire on port 1: fire held, up released on the same tick.
        bus.autofire_en[1] = 1'b1;
        align();
        bus.joy1_raw = 5'b01111;
        wait_joy(0, 5'b10000, 20, n);
        chk("af_lat", n, 13);
        got = '0;
        for (int j = 0; j < 24; j++) begin
            got = {got[22:0], bus.joy1[JOY_FIRE]};
            @(negedge clk);
        end
        chk("af_pattern", got, 24'hFF00FF);
        chk("af_phase0", bus.joy1, 5'b00000);
        bus.autofire_en[1] = 1'b0;
        step(1);
        chk("af_off", bus.joy1, 5'b10000);
        bus.autofire_en[1] = 1'b1;
        step(1);
        chk("af_reen", bus.joy1, 5'b10000);

        bus.autofire_en[1] = 1'b0;
        align();
        bus.joy1_raw = 5'b11111;
        wait_joy(0, 5'b00000, 20, n);
        chk("af_rel_lat", n, 13);

        bus.autofire_en[1] = 1'b1;
        align();
        bus.joy1_raw = 5'b01111;
        wait_joy(0, 5'b10000, 20, n);
        chk("af_repress_lat", n, 13);
        hi = 0;
        for (int j = 0; j < 8; j++) begin
            hi += int'(bus.joy1[JOY_FIRE]);
            @(negedge clk);
        end
        chk("af_repress_hi", hi, 8);
        chk("af_repress_low", bus.joy1[JOY_FIRE], 0);
        bus.autofire_en[1] = 1'b0;
        align();
        bus.joy1_raw = 5'b11111;
        wait_joy(0, 5'b00000, 20, n);
        chk("af_rel2_lat", n, 13);

        // SOCD on port 2: left+right+up pressed.
        bus.socd_block = 1'b1;
        align();
        bus.joy2_raw = 5'b10010;
        wait_joy(1, 5'b00001, 20, n);
        chk("socd_lat", n, 13);
        chk("socd_chg", bus.joy_change, 1);
        step(1);
        chk("socd_chg_1cyc", bus.joy_change, 0);
        bus.socd_block = 1'b0;
        step(1);
        chk("socd_off", bus.joy2, 5'b01101);
        bus.socd_block = 1'b1;
        step(1);
        chk("socd_on", bus.joy2, 5'b00001);

        // Add down: both axes cancel, yet the debounced change still strobes.
        align();
        bus.joy2_raw = 5'b10000;
        step(12);
        chk("socd_ud_pre", {bus.joy2, bus.joy_change}, {5'b00001, 1'b0});
        step(1);
        chk("socd_ud", {bus.joy2, bus.joy_change}, {5'b00000, 1'b1});
        bus.socd_block = 1'b0;
        step(1);
        chk("socd_ud_off", bus.joy2, 5'b01111);

        // Both ports change on the same tick.
        align();
        p0 = pulses;
        bus.joy1_raw = 5'b10111;
        bus.joy2_raw = 5'b11111;
        step(12);
        chk("sim_pre", {bus.joy1, bus.joy2, bus.joy_change}, {5'b00000, 5'b01111, 1'b0});
        step(1);
        chk("sim_upd", {bus.joy1, bus.joy2, bus.joy_change}, {5'b01000, 5'b00000, 1'b1});
        step(1);
        chk("sim_chg_off", bus.joy_change, 0);
        step(2);
        chk("sim_pulse", pulses - p0, 1);

        // Reset mid-count while a new press is still being debounced.
        align();
        step(2);
        bus.joy1_raw = 5'b00000;
        step(3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {bus.joy1, bus.joy2, bus.joy_change}, 0);
        step(2);
        p0 = pulses;
        reset_n = 1'b1;
        wait_joy(0, 5'b11111, 20, n);
        chk("mid_rst_lat", n, 13);
        step(3);
        chk("mid_rst_pulse", pulses - p0, 1);
        chk("chg_width", long_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
# joystick_conditioner

Conditions the two raw, active-low Pmod joystick ports before they reach the mainboard `joy1`/`joy2` inputs. Each bit is synchronised, inverted, and debounced on a slow sample tick. Optional per-port autofire and opposing-direction suppression are applied. The block produces registered, active-high joystick vectors plus a one-cycle change strobe for the service processor.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clk cycles per sample tick (≥2).
- `DEBOUNCE_TICKS`, default 8: consecutive differing ticks required to accept a new level (≥1).
- `AUTOFIRE_TICKS`, default 64: ticks per autofire half-period (≥1).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `joy1_raw` in [0:4]: port 1 pins, active-low, asynchronous; order {fire, left, right, down, up}.
- `joy2_raw` in [0:4]: port 2 pins, same format.
- `autofire_en` in [1:2]: per-port autofire enable, synchronous.
- `socd_block` in 1: when 1, opposing directions that are both pressed cancel.
- `joy1` out [0:4]: conditioned port 1, active-high, same order.
- `joy2` out [0:4]: conditioned port 2.
- `joy_change` out 1: one-cycle pulse when any debounced bit of either port changes.

## Operation
- Synchroniser: 2-FF per raw bit; flops reset to 1 (released); output inverted to active-high `s[i]`.
- Prescaler: counter 0..TICK_DIV-1, wraps. `tick` is high for one cycle at count TICK_DIV-1.
- Debounce, per bit, state `d[i]` plus counter `c[i]` of width clog2(DEBOUNCE_TICKS+1). On `tick`:
  - if `s[i]==d[i]`: `c[i]←0`;
  - else if `c[i]==DEBOUNCE_TICKS-1`: `d[i]←s[i]`, `c[i]←0`;
  - else `c[i]←c[i]+1`.
  - Any equal tick restarts the count. No update between ticks.
- Autofire, per port, phase counter `a` plus phase bit `p`:
  - When `autofire_en` and `d[fire]` are both 1: on each tick `a` increments. At AUTOFIRE_TICKS-1, `a←0` and `p` toggles.
  - `p` starts at 1, so the first fire output is asserted immediately.
  - When fire is released or autofire is disabled: `a←0`, `p←1` in the same cycle.
  - Fire output = `d[fire] & (autofire_en ? p : 1)`.
- SOCD: if `socd_block` and `d[left]&d[right]`, both left and right output 0. Up/down are handled independently in the same way. Fire is unaffected.
- `joy_change` asserts the cycle after any `d[i]` of either port changes. Autofire toggles and SOCD masking do not assert it.

## Timing
- Reset values: `joy1=joy2=0`, `joy_change=0`; all counters 0; `p=1`; sync flops 1. Reset is asynchronous and takes effect mid-tick or mid-count; release needs no recovery sequence beyond the first tick.
- All outputs are registered.
- Output latency: a stable input edge appears on `joyN` 2 (sync) + wait-to-tick + (DEBOUNCE_TICKS-1)·TICK_DIV + 1 cycles later. Worst case ≈ DEBOUNCE_TICKS·TICK_DIV + 3.
- `socd_block` and `autofire_en` changes reach outputs 1 cycle later. No tick is required.
- Simultaneous events: a debounce acceptance and an autofire wrap on the same tick both take effect. If fire is released on that tick, the release wins: `p←1`, output 0.
- `joy_change` is never held longer than 1 cycle, even when both ports change on the same tick.

## Structure
- Package `joy_pkg`: index constants `JOY_FIRE=0`, `JOY_LEFT=1`, `JOY_RIGHT=2`, `JOY_DOWN=3`, `JOY_UP=4`, and `JOY_BITS=5`.
- Sub-module `joy_port`, instantiated twice, holds:
  - synchroniser, debounce, autofire and SOCD for one port;
  - a shared `tick` input;
  - a `changed` output.
- The top holds the prescaler and ORs the two `changed` outputs into the `joy_change` register.

## Test plan
Use TICK_DIV=4, DEBOUNCE_TICKS=3, AUTOFIRE_TICKS=2 unless noted.
- Reset check: assert `reset_n=0` mid-count with `joy1_raw=5'b00000` held → outputs 0 during reset. After release, `joy1=5'b11111` after 3 accepted ticks. `joy_change` pulses exactly once.
- Glitch rejection: bounce up-pin low for 2 ticks, then high → `joy1[JOY_UP]` stays 0 and `joy_change` stays 0. Held low for 3 ticks → asserts within ≤15 cycles.
- Autofire: `autofire_en[1]=1`, fire held → `joy1[JOY_FIRE]` is 1 for 2 ticks, 0 for 2 ticks, repeating. On release it goes to 0 within 1 cycle; on re-press it starts at 1.
- SOCD: left+right both held with `socd_block=1` → `joy2[1:2]=2'b00` while up still passes. Setting `socd_block=0` gives `2'b11` on the next cycle.
- Simultaneous change: both ports change on the same tick → a single one-cycle `joy_change`, and both vectors update in the same cycle.
